// File: rtl/alu_operand_loader.sv
// Board front end for the combinational ALU: debounces three load buttons, captures
// operand A, operand B and the opcode from the switches, and registers the ALU result.
module alu_operand_loader #(
  parameter int NB_DATA         = 4,
  parameter int NB_OP           = 6,
  parameter int NB_SW           = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_leds,
  output logic               o_valid,
  output logic [1:0]         o_state,
  output logic               o_err
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W  = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_DONE  = ST_W'(DEBOUNCE_CYCLES + 2);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  function automatic logic op_supported(input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_supported = 1'b1;
      default:                        op_supported = 1'b0;
    endcase
  endfunction

  // Button index: 0 = A, 1 = B, 2 = OP
  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [ST_W-1:0]  st_q, st_d;
  logic             settle_done;
  logic [2:0]       pulse;

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   a_q, a_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_OP-1:0]     op_q, op_d;
  logic [NB_DATA-1:0]   leds_q, leds_d;
  logic                 err_q, err_d;
  logic                 ld_a, ld_b, op_try, ld_op;

  assign btn_raw     = {i_btn_op, i_btn_b, i_btn_a};
  assign settle_done = (st_q == ST_DONE);

  // A button still held across reset settles high while disarmed, so its first
  // edge is swallowed; arming happens only once the debounced level is seen low.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = deb_q;
    deb_d   = deb_q;
    st_d    = settle_done ? st_q : st_q + ST_W'(1);
    armed_d = armed_q | ({3{settle_done}} & ~deb_q);
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    pulse = deb_q & ~prev_q & armed_q;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      st_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      st_q    <= st_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state_q <= WAIT_A;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  if (ld_a)  state_d = WAIT_B;
      WAIT_B:  if (ld_b)  state_d = WAIT_OP;
      WAIT_OP: if (ld_op) state_d = SHOW;
      SHOW:    state_d = SHOW;
      default: state_d = WAIT_A;
    endcase
  end

  // In SHOW a single pulse acts per cycle, A first, then B, then OP
  always_comb begin
    ld_a    = pulse[0] & ((state_q == WAIT_A) | (state_q == SHOW));
    ld_b    = pulse[1] & ((state_q == WAIT_B) | ((state_q == SHOW) & ~pulse[0]));
    op_try  = pulse[2] & ((state_q == WAIT_OP) |
                          ((state_q == SHOW) & ~pulse[0] & ~pulse[1]));
    ld_op   = op_try & op_supported(i_sw[NB_OP-1:0]);
    err_d   = op_try & ~op_supported(i_sw[NB_OP-1:0]);
    o_valid = (state_q == SHOW);
    o_state = state_q;
  end

  always_comb begin
    a_d    = ld_a  ? i_sw[NB_DATA-1:0] : a_q;
    b_d    = ld_b  ? i_sw[NB_DATA-1:0] : b_q;
    op_d   = ld_op ? i_sw[NB_OP-1:0]   : op_q;
    leds_d = (state_q == SHOW) ? i_alu_result : '0;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      leds_q <= '0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      leds_q <= leds_d;
      err_q  <= err_d;
    end
  end

  assign o_datoA     = a_q;
  assign o_datoB     = b_q;
  assign o_operation = op_q;
  assign o_leds      = leds_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window and a
// behavioural ALU closing the loop from o_datoA/o_datoB/o_operation to i_alu_result.
module tb_alu_operand_loader;

  localparam int NB_DATA = 4;
  localparam int NB_OP   = 6;
  localparam int NB_SW   = 6;
  localparam int DEB     = 4;

  logic               clk;
  logic               i_reset;
  logic [NB_SW-1:0]   i_sw;
  logic               i_btn_a, i_btn_b, i_btn_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_datoA, o_datoB, o_leds;
  logic [NB_OP-1:0]   o_operation;
  logic               o_valid, o_err;
  logic [1:0]         o_state;

  int n_chk  = 0;
  int n_fail = 0;

  alu_operand_loader #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_SW(NB_SW), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_sw(i_sw),
    .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
    .i_alu_result(i_alu_result),
    .o_datoA(o_datoA), .o_datoB(o_datoB), .o_operation(o_operation),
    .o_leds(o_leds), .o_valid(o_valid), .o_state(o_state), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [5:0] op);
    case (op)
      6'b100000: alu_model = a + b;
      6'b100010: alu_model = a - b;
      6'b100100: alu_model = a & b;
      6'b100101: alu_model = a | b;
      6'b100110: alu_model = a ^ b;
      6'b100111: alu_model = ~(a | b);
      6'b000011: alu_model = 4'($signed(a) >>> b);
      6'b000010: alu_model = a >> b;
      default:   alu_model = 4'h0;
    endcase
  endfunction

  always_comb i_alu_result = alu_model(o_datoA, o_datoB, o_operation);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int bounce [12] = '{3, 1, 2, 2, 1, 1, 3, 1, 2, 2, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_sw = '0;
    i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;

    // 1. reset held with A pressed
    i_sw = 6'h3F; i_btn_a = 1'b1;
    cyc(3);
    chk("rst_datoA", 32'(o_datoA), 32'h0);
    chk("rst_datoB", 32'(o_datoB), 32'h0);
    chk("rst_op",    32'(o_operation), 32'h0);
    chk("rst_leds",  32'(o_leds), 32'h0);
    chk("rst_valid_err_state", {29'b0, o_valid, o_state}, 32'h0);
    chk("rst_err",   32'(o_err), 32'h0);
    i_reset = 1'b0;
    cyc(15);
    chk("held_no_load_A", 32'(o_datoA), 32'h0);
    chk("held_state",     32'(o_state), 32'h0);
    i_btn_a = 1'b0;
    cyc(12);

    // 2. ADD sequence
    i_sw = 6'b000011; i_btn_a = 1'b1;
    cyc(7);
    chk("add_datoA", 32'(o_datoA), 32'h3);
    chk("add_stateB", 32'(o_state), 32'h1);
    i_btn_a = 1'b0; cyc(10);
    i_sw = 6'b000101; i_btn_b = 1'b1;
    cyc(7);
    chk("add_datoB", 32'(o_datoB), 32'h5);
    chk("add_stateOP", 32'(o_state), 32'h2);
    i_btn_b = 1'b0; cyc(10);
    i_sw = 6'b100000; i_btn_op = 1'b1;
    cyc(7);
    chk("add_op",    32'(o_operation), 32'h20);
    chk("add_valid", 32'(o_valid), 32'h1);
    chk("add_state", 32'(o_state), 32'h3);
    chk("add_leds_early", 32'(o_leds), 32'h0);
    cyc(1);
    chk("add_leds", 32'(o_leds), 32'h8);
    i_btn_op = 1'b0; cyc(10);

    // 3. bounce rejection on A in SHOW
    i_sw = 6'h07;
    for (int k = 0; k < 12; k++) begin
      i_btn_a = (k % 2 == 0);
      cyc(bounce[k]);
    end
    chk("bounce_no_load", 32'(o_datoA), 32'h3);
    i_btn_a = 1'b1;
    cyc(6);
    chk("bounce_before_7", 32'(o_datoA), 32'h3);
    cyc(1);
    chk("bounce_at_7", 32'(o_datoA), 32'h7);
    i_sw = 6'h09;
    cyc(3);
    chk("bounce_single_load", 32'(o_datoA), 32'h7);
    chk("bounce_leds", 32'(o_leds), 32'hC);
    i_btn_a = 1'b0; cyc(10);

    // 4. invalid opcode in WAIT_OP
    i_reset = 1'b1; cyc(2); i_reset = 1'b0; cyc(10);
    i_sw = 6'h09; i_btn_a = 1'b1; cyc(7); i_btn_a = 1'b0; cyc(10);
    i_sw = 6'h03; i_btn_b = 1'b1; cyc(7); i_btn_b = 1'b0; cyc(10);
    chk("inv_pre_state", 32'(o_state), 32'h2);
    i_sw = 6'b111111; i_btn_op = 1'b1;
    cyc(7);
    chk("inv_err", 32'(o_err), 32'h1);
    chk("inv_state", 32'(o_state), 32'h2);
    chk("inv_op", 32'(o_operation), 32'h0);
    cyc(1);
    chk("inv_err_one_cycle", 32'(o_err), 32'h0);
    i_btn_op = 1'b0; cyc(10);
    i_sw = 6'b100010; i_btn_op = 1'b1;
    cyc(7);
    chk("sub_state", 32'(o_state), 32'h3);
    chk("sub_op", 32'(o_operation), 32'h22);
    cyc(1);
    chk("sub_leds", 32'(o_leds), 32'h6);
    i_btn_op = 1'b0; cyc(10);

    // 5. live edit of B in SHOW
    i_sw = 6'b000001; i_btn_b = 1'b1;
    cyc(7);
    chk("edit_datoB", 32'(o_datoB), 32'h1);
    chk("edit_leds_old", 32'(o_leds), 32'h6);
    cyc(1);
    chk("edit_leds_new", 32'(o_leds), 32'h8);
    chk("edit_state", 32'(o_state), 32'h3);
    i_btn_b = 1'b0; cyc(10);

    i_sw = 6'b111111; i_btn_op = 1'b1;
    cyc(7);
    chk("show_inv_err", 32'(o_err), 32'h1);
    chk("show_inv_op_kept", 32'(o_operation), 32'h22);
    i_btn_op = 1'b0; cyc(10);

    i_sw = 6'h0E; i_btn_a = 1'b1; i_btn_b = 1'b1;
    cyc(7);
    chk("prio_datoA", 32'(o_datoA), 32'hE);
    chk("prio_datoB_kept", 32'(o_datoB), 32'h1);
    cyc(1);
    chk("prio_leds", 32'(o_leds), 32'hD);
    i_btn_a = 1'b0; i_btn_b = 1'b0; cyc(10);

    // 6. wrong button ignored, then async reset in WAIT_OP
    i_reset = 1'b1; cyc(2); i_reset = 1'b0; cyc(10);
    i_sw = 6'h06; i_btn_b = 1'b1;
    cyc(7);
    chk("waitA_ignore_B_state", 32'(o_state), 32'h0);
    chk("waitA_ignore_B_dato", 32'(o_datoB), 32'h0);
    i_btn_b = 1'b0; cyc(10);
    i_sw = 6'h05; i_btn_a = 1'b1; cyc(7); i_btn_a = 1'b0; cyc(10);
    i_sw = 6'h06; i_btn_b = 1'b1; cyc(7); i_btn_b = 1'b0; cyc(10);
    chk("arst_pre_state", 32'(o_state), 32'h2);
    chk("arst_pre_datoA", 32'(o_datoA), 32'h5);
    @(posedge clk);
    #2 i_reset = 1'b1;
    #1;
    chk("arst_datoA", 32'(o_datoA), 32'h0);
    chk("arst_datoB", 32'(o_datoB), 32'h0);
    chk("arst_state", 32'(o_state), 32'h0);
    @(negedge clk);
    i_reset = 1'b0;
    cyc(2);
    chk("arst_after_state", 32'(o_state), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Front end that drives the combinational ALU from board switches and three push-buttons; it is the initiator side of the ALU's i_datoA/i_datoB/i_operation interface.
- Synchronises and debounces the buttons, then captures operand A, operand B and the opcode in sequence.
- Presents the captured values to the ALU and registers the ALU result onto the LEDs.
- Sits between board I/O and the ALU in the FPGA top level.

Parameters:
- NB_DATA, 4, operand and result width.
- NB_OP, 6, opcode width.
- NB_SW, 6, switch bus width; must be >= max(NB_DATA, NB_OP).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change; the bench uses 4.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_sw  in  NB_SW  raw switches; sampled on a load pulse.
- i_btn_a  in  1  raw button: load operand A.
- i_btn_b  in  1  raw button: load operand B.
- i_btn_op  in  1  raw button: load opcode.
- i_alu_result  in  NB_DATA  ALU output (o_leds of the ALU).
- o_datoA  out  NB_DATA  to ALU i_datoA.
- o_datoB  out  NB_DATA  to ALU i_datoB.
- o_operation  out  NB_OP  to ALU i_operation.
- o_leds  out  NB_DATA  registered result shown to the user.
- o_valid  out  1  high while in SHOW (all three fields loaded).
- o_state  out  2  current FSM state, for debug LEDs.
- o_err  out  1  one-cycle pulse when an unsupported opcode is rejected.

Behaviour:
- Reset (async assert, sync release):
  - All registers go to 0.
  - FSM goes to WAIT_A.
  - Synchroniser flops, debounce counters and debounced levels are cleared.
  - Reset mid-press: no pulse is generated until the button has been released and pressed again.
- Per-button input chain:
  - 2-flop synchroniser.
  - Debounce counter: counts while the synchronised value differs from the debounced level. It resets to 0 whenever they match. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Rising-edge detect on the debounced level gives a 1-cycle load pulse.
  - Latency from a clean press to the pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Loads:
  - On a pulse, the target register takes i_sw in the same clock edge.
  - A and B take i_sw[NB_DATA-1:0]; the opcode takes i_sw[NB_OP-1:0].
  - The new value appears on the output the cycle after the pulse.
- Valid opcodes (anything else is rejected):
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR
  - 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL
- FSM states: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3.
  - WAIT_A: the A pulse loads A and moves to WAIT_B. Other pulses are ignored.
  - WAIT_B: the B pulse loads B and moves to WAIT_OP. Other pulses are ignored.
  - WAIT_OP: the OP pulse with a valid opcode loads it and moves to SHOW. With an invalid opcode, o_operation is unchanged, o_err pulses for 1 cycle, and the FSM stays in WAIT_OP.
  - SHOW: any pulse reloads its own field (live edit) and the FSM stays in SHOW. An invalid opcode in SHOW is rejected with o_err and the old opcode is kept.
- Simultaneous pulses:
  - In WAIT states, only the expected button acts.
  - In SHOW, priority is A > B > OP; lower-priority pulses in the same cycle are dropped.
- o_leds:
  - Holds 0 outside SHOW.
  - In SHOW, o_leds takes i_alu_result every cycle (1-cycle register latency from the ALU inputs).
  - After a live edit, the new result shows 2 cycles after the pulse.
- o_valid equals (state == SHOW).
- No wrap or arithmetic inside this block; widths pass through unchanged, with upper switch bits truncated for operands.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset:
   - Stimulus: hold i_reset for 3 cycles with i_sw=6'h3F and i_btn_a held high.
   - Required: all outputs 0; o_state=0; no A load after release until the button is released and pressed again.
2. Full ADD sequence:
   - Stimulus: i_sw=000011, press A; i_sw=000101, press B; i_sw=100000, press OP; ALU model returns A+B.
   - Required: o_datoA=0011, o_datoB=0101, o_operation=100000, o_valid=1, o_leds=1000 two cycles after the OP pulse.
3. Bounce rejection:
   - Stimulus: toggle i_btn_a with 1-3-cycle pulses for 20 cycles, then hold high for 10 cycles.
   - Required: exactly one A load, occurring 7 cycles after the stable-high start.
4. Invalid opcode:
   - Stimulus: in WAIT_OP, i_sw=111111, press OP.
   - Required: o_err high for 1 cycle; o_state stays 2; o_operation=000000.
   - Then: i_sw=100010, press OP. Required: SHOW, and o_leds shows A-B.
5. Live edit in SHOW:
   - Stimulus: press B with i_sw=000001.
   - Required: o_datoB=0001 the next cycle; o_leds updates 2 cycles after the pulse; o_state stays 3.
6. Async reset mid-sequence:
   - Stimulus: assert i_reset between cycle edges while in WAIT_OP.
   - Required: outputs clear immediately without waiting for clk; state returns to WAIT_A.
